// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and helpers for the cpu-to-byte-bus serialiser
package bus_pkg;

  localparam int BusDataWidth = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    DONE     = 2'd2
  } state_t;

  // funct3[1:0] encoding; the unused code 3 behaves as a word access
  typedef enum logic [1:0] {
    Byte = 2'd0,
    Half = 2'd1,
    Word = 2'd2
  } access_size_t;

  function automatic logic [2:0] bytes_for(input access_size_t size);
    case (size)
      Byte:    return 3'd1;
      Half:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bus_serialiser_if.sv
// rtl/bus_serialiser_if.sv - byte-wide handshaked external bus
interface bus_serialiser_if #(
  parameter int ADDRESS_WIDTH = 8
);
  import bus_pkg::*;

  logic                     bus_valid;
  logic                     bus_ready;
  logic [ADDRESS_WIDTH-1:0] bus_address;
  logic                     bus_write_enable;
  logic [BusDataWidth-1:0]  bus_write_data;
  logic [BusDataWidth-1:0]  bus_read_data;

  modport master (
    output bus_valid, bus_address, bus_write_enable, bus_write_data,
    input  bus_ready, bus_read_data
  );

  modport slave (
    input  bus_valid, bus_address, bus_write_enable, bus_write_data,
    output bus_ready, bus_read_data
  );

endinterface

// File: rtl/byte_lane_assembler.sv
// rtl/byte_lane_assembler.sv - load byte lanes plus sign/zero extension
module byte_lane_assembler
  import bus_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_write,
  input  logic [1:0]  i_index,
  input  logic [7:0]  i_byte,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [7:0] r_lane [4];
  logic [7:0] w_view [4];

  // lanes are cleared at accept so bytes never received on a timeout read as zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_lane[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < 4; i++) r_lane[i] <= '0;
    end else if (i_write) begin
      r_lane[i_index] <= i_byte;
    end
  end

  // bypass the byte being captured so the result is ready on the final handshake
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_view[i] = (i_write && (i_index == 2'(i))) ? i_byte : r_lane[i];
    end
  end

  // extension mux: byte and half take their sign from the top received lane
  always_comb begin
    o_result = {w_view[3], w_view[2], w_view[1], w_view[0]};
    case (access_size_t'(i_size))
      Byte:    o_result = {{24{~i_unsigned & w_view[0][7]}}, w_view[0]};
      Half:    o_result = {{16{~i_unsigned & w_view[1][7]}}, w_view[1], w_view[0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_serialiser.sv
// rtl/bus_serialiser.sv - serialises cpu load/store requests onto an 8-bit bus
module bus_serialiser
  import bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read_enable,
  input  logic        cpu_write_enable,
  input  logic [31:0] cpu_address,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        stall,
  output logic        error,
  bus_serialiser_if.master bus
);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [1:0]               r_size;
  logic [1:0]               r_index;
  logic                     r_unsigned;
  logic                     r_write;
  logic [31:0]              r_write_data;
  logic [31:0]              r_read_data;
  logic [7:0]               r_timeout;
  logic                     r_error;

  logic        w_request;
  logic        w_accept;
  logic        w_handshake;
  logic        w_last;
  logic        w_timeout;
  logic        w_lane_write;
  logic [31:0] w_result;
  logic        w_unused_address;

  assign w_unused_address = &{1'b0, cpu_address[31:ADDRESS_WIDTH]};

  assign w_request    = cpu_read_enable | cpu_write_enable;
  assign w_accept     = (r_state == IDLE) & w_request;
  assign w_handshake  = (r_state == TRANSFER) & bus.bus_ready;
  assign w_last       = ({1'b0, r_index} == (bytes_for(access_size_t'(r_size)) - 3'd1));
  assign w_timeout    = (r_timeout == 8'(TIMEOUT_CYCLES - 1));
  assign w_lane_write = w_handshake & ~r_write;

  assign bus.bus_address      = r_address + ADDRESS_WIDTH'(r_index);
  assign bus.bus_write_enable = r_write & (r_state == TRANSFER);
  assign bus.bus_write_data   = r_write_data[{r_index, 3'b000} +: 8];
  assign cpu_read_data        = r_read_data;
  assign error                = r_error;

  byte_lane_assembler u_lanes (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_accept),
    .i_write    (w_lane_write),
    .i_index    (r_index),
    .i_byte     (bus.bus_read_data),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_result)
  );

  // state register; async reset drops bus_valid immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // next state plus stall/valid; the idle stall is gated so reset releases the cpu at once
  always_comb begin
    w_next_state  = r_state;
    stall         = 1'b0;
    bus.bus_valid = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_request & ~reset;
        if (w_request) w_next_state = TRANSFER;
      end
      TRANSFER: begin
        stall         = 1'b1;
        bus.bus_valid = 1'b1;
        if (bus.bus_ready) begin
          if (w_last) w_next_state = DONE;
        end else if (w_timeout) begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // request latch, beat index, timeout counter and load result register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_address    <= '0;
      r_size       <= '0;
      r_index      <= '0;
      r_unsigned   <= 1'b0;
      r_write      <= 1'b0;
      r_write_data <= '0;
      r_read_data  <= '0;
      r_timeout    <= '0;
      r_error      <= 1'b0;
    end else if (w_accept) begin
      r_address    <= cpu_address[ADDRESS_WIDTH-1:0];
      r_size       <= cpu_size;
      r_unsigned   <= cpu_unsigned;
      r_write      <= cpu_write_enable;
      r_write_data <= cpu_write_data;
      r_index      <= '0;
      r_timeout    <= '0;
    end else if (r_state == TRANSFER) begin
      if (bus.bus_ready) begin
        r_timeout <= '0;
        if (w_last) begin
          if (!r_write) r_read_data <= w_result;
        end else begin
          r_index <= r_index + 2'd1;
        end
      end else if (w_timeout) begin
        r_error <= 1'b1;
        if (!r_write) r_read_data <= w_result;
      end else begin
        r_timeout <= r_timeout + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_serialiser.sv
// tb/tb_bus_serialiser.sv - self-checking bench for bus_serialiser
module tb_bus_serialiser;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_read_enable;
  logic        cpu_write_enable;
  logic [31:0] cpu_address;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_write_data;
  logic [31:0] cpu_read_data;
  logic        stall;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_rdata;

  bus_serialiser_if #(.ADDRESS_WIDTH(8)) bus ();

  bus_serialiser #(.ADDRESS_WIDTH(8), .TIMEOUT_CYCLES(15)) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_read_enable  (cpu_read_enable),
    .cpu_write_enable (cpu_write_enable),
    .cpu_address      (cpu_address),
    .cpu_size         (cpu_size),
    .cpu_unsigned     (cpu_unsigned),
    .cpu_write_data   (cpu_write_data),
    .cpu_read_data    (cpu_read_data),
    .stall            (stall),
    .error            (error),
    .bus              (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rbytes;
    int          delay;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // expected load result from the bytes the bus actually delivered
  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] rbytes, input int n_recv);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n_recv; i++) v = v | (rbytes & (32'hFF << (8 * i)));
    if (!uns && nbytes(size) == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!uns && nbytes(size) == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // one cpu request, acting as bus slave; ready appears after 'delay' wait cycles per beat
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] rbytes, input int delay, input bit never_ready,
                         input int exp_stall, input logic [31:0] exp_rdata, input logic exp_err);
    int n_beats   = 0;
    int stall_cnt = 0;
    int wait_cnt  = 0;
    cpu_read_enable  = rd;
    cpu_write_enable = wr;
    cpu_address      = addr;
    cpu_size         = size;
    cpu_unsigned     = uns;
    cpu_write_data   = wdata;
    #1;
    while (stall && stall_cnt < 100) begin
      stall_cnt++;
      bus.bus_ready = 1'b0;
      if (bus.bus_valid && !never_ready) begin
        if (wait_cnt == delay) begin
          check("beat_address", 32'(bus.bus_address), 32'(8'(addr + 32'(n_beats))));
          check("beat_write_enable", 32'(bus.bus_write_enable), 32'(wr));
          if (wr) check("beat_write_data", 32'(bus.bus_write_data), 32'(8'(wdata >> (8 * n_beats))));
          bus.bus_ready     = 1'b1;
          bus.bus_read_data = 8'(rbytes >> (8 * n_beats));
          n_beats++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      tick();
    end
    bus.bus_ready = 1'b0;
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check("beat_count", 32'(n_beats), never_ready ? 32'd0 : 32'(nbytes(size)));
    check("done_bus_valid", 32'(bus.bus_valid), 32'd0);
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b0;
    tick();
    check("no_reaccept", 32'(bus.bus_valid), 32'd0);
    check("cpu_read_data", cpu_read_data, exp_rdata);
    check("error", 32'(error), 32'(exp_err));
  endtask

  initial begin
    logic        rd, wr, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rbytes, exp_rd;
    int          delay, op;

    tbl[0] = '{1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 0, 5, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0, 32'h80, 0, 2, 32'hFFFFFF80};
    tbl[2] = '{1'b1, 1'b0, 32'h20, 2'd0, 1'b1, 32'h0, 32'h80, 0, 2, 32'h00000080};
    tbl[3] = '{1'b1, 1'b0, 32'hFF, 2'd1, 1'b0, 32'h0, 32'h9234, 3, 9, 32'hFFFF9234};
    tbl[4] = '{1'b1, 1'b1, 32'h40, 2'd2, 1'b0, 32'h11223344, 32'hCAFEF00D, 0, 5, 32'hFFFF9234};
    tbl[5] = '{1'b1, 1'b0, 32'h7E, 2'd3, 1'b1, 32'h0, 32'hA1B2C3D4, 1, 9, 32'hA1B2C3D4};
    tbl[6] = '{1'b1, 1'b0, 32'h100, 2'd1, 1'b1, 32'h0, 32'h8001, 0, 3, 32'h00008001};
    tbl[7] = '{1'b1, 1'b0, 32'hFFFFFFF0, 2'd0, 1'b0, 32'h0, 32'h7F, 2, 4, 32'h0000007F};

    reset             = 1'b1;
    cpu_read_enable   = 1'b0;
    cpu_write_enable  = 1'b0;
    cpu_address       = 32'h0;
    cpu_size          = 2'd0;
    cpu_unsigned      = 1'b0;
    cpu_write_data    = 32'h0;
    bus.bus_ready     = 1'b0;
    bus.bus_read_data = 8'h0;
    tick();
    tick();
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_bus_valid", 32'(bus.bus_valid), 32'd0);
    check("reset_bus_address", 32'(bus.bus_address), 32'd0);
    check("reset_bus_write_enable", 32'(bus.bus_write_enable), 32'd0);
    check("reset_bus_write_data", 32'(bus.bus_write_data), 32'd0);
    check("reset_cpu_read_data", cpu_read_data, 32'd0);
    check("reset_error", 32'(error), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata,
              tbl[i].rbytes, tbl[i].delay, 1'b0, tbl[i].exp_stall, tbl[i].exp_rdata, 1'b0);
    end
    m_rdata = tbl[7].exp_rdata;

    for (int i = 0; i < 24; i++) begin
      op     = int'($urandom_range(0, 2));
      rd     = (op != 1);
      wr     = (op != 0);
      addr   = $urandom;
      size   = 2'($urandom_range(0, 3));
      uns    = 1'($urandom_range(0, 1));
      wdata  = $urandom;
      rbytes = $urandom;
      delay  = int'($urandom_range(0, 3));
      if (!wr) m_rdata = ref_load(size, uns, rbytes, nbytes(size));
      exp_rd = m_rdata;
      run_txn(rd, wr, addr, size, uns, wdata, rbytes, delay, 1'b0,
              1 + nbytes(size) * (delay + 1), exp_rd, 1'b0);
    end

    // timeout: ready never comes, the load completes with zero data and sets error
    run_txn(1'b1, 1'b0, 32'h33, 2'd0, 1'b0, 32'h0, 32'hFF, 0, 1'b1, 16, 32'h0, 1'b1);
    // the next request is still serviced and error stays set
    run_txn(1'b1, 1'b0, 32'h05, 2'd0, 1'b1, 32'h0, 32'hE5, 0, 1'b0, 2, 32'h000000E5, 1'b1);

    // reset during the second beat of a word store
    bus.bus_ready    = 1'b1;
    cpu_write_enable = 1'b1;
    cpu_address      = 32'h50;
    cpu_size         = 2'd2;
    cpu_write_data   = 32'h0BADF00D;
    tick();
    tick();
    check("beat2_address", 32'(bus.bus_address), 32'h51);
    check("beat2_valid", 32'(bus.bus_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_bus_valid", 32'(bus.bus_valid), 32'd0);
    check("reset_mid_stall", 32'(stall), 32'd0);
    cpu_write_enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_idle", 32'(bus.bus_valid), 32'd0);
    end
    check("post_reset_error", 32'(error), 32'd0);
    check("post_reset_read_data", cpu_read_data, 32'd0);
    bus.bus_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_serialiser.md
Name: bus_serialiser

Overview:
- Sits directly downstream of the cpu memory port. Consumes one 32-bit load/store request per instruction and serialises it into byte-wide handshaked transactions on the 8-bit external bus (TinyTapeout pins).
- Asserts stall to the cpu until the transfer completes.
- Returns assembled, sign- or zero-extended load data to the cpu register write-back mux.

Parameters:
ADDRESS_WIDTH, 8, width of external byte address; addresses wrap modulo 2^ADDRESS_WIDTH
TIMEOUT_CYCLES, 15, maximum cycles to wait for bus_ready on one byte before aborting (1..255)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpu_read_enable  input  1  load request (level, held while stalled)
cpu_write_enable  input  1  store request (level, held while stalled)
cpu_address  input  32  byte address from alu_result; low ADDRESS_WIDTH bits used
cpu_size  input  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 treated as word
cpu_unsigned  input  1  funct3[2]: zero-extend load result
cpu_write_data  input  32  store data (register_read_data_2)
cpu_read_data  output  32  extended load result
stall  output  1  cpu must hold program_counter and all state
error  output  1  sticky timeout flag
bus_valid  output  1  byte transaction request
bus_ready  input  1  external acceptance / read data valid
bus_address  output  ADDRESS_WIDTH  byte address
bus_write_enable  output  1  1 = write byte, 0 = read byte
bus_write_data  output  8  store byte
bus_read_data  input  8  load byte

Behaviour:
- Clock is `clock`. Reset is asynchronous and active-high on `reset`.
- Reset values: state IDLE; all byte-lane, index, timeout and latched registers 0; cpu_read_data 0; error 0; bus_valid 0; bus_write_enable 0; bus_address 0; bus_write_data 0.
- Reset asserted mid-transfer aborts immediately: bus_valid falls asynchronously and no partial write-back occurs.
- States: IDLE, TRANSFER, DONE.
- IDLE:
  - Request = cpu_read_enable | cpu_write_enable. If both are asserted, the write wins.
  - On request: latch address, size, unsigned flag, write data and direction; index <= 0; go to TRANSFER.
  - stall = request (combinational). With no request, stall = 0.
- TRANSFER:
  - stall = 1; bus_valid = 1.
  - bus_address = latched_address + index, truncated to ADDRESS_WIDTH, so it wraps: base 0xFF + 1 -> 0x00.
  - bus_write_enable = latched direction.
  - bus_write_data = latched_data[8*index +: 8], little-endian.
  - Byte count: 1 / 2 / 4 for size 00 / 01 / 10 or 11.
  - On bus_valid & bus_ready: reads capture bus_read_data into lane[index]; timeout counter cleared. If index == count-1 go to DONE, else index++.
  - Without bus_ready: timeout counter increments. When it reaches TIMEOUT_CYCLES: error <= 1; unreceived lanes read as 0x00; go to DONE.
- DONE:
  - Exactly one cycle; stall = 0, so the cpu advances on this edge.
  - For reads, cpu_read_data <= extended lanes:
    - byte: lane0[7] sign, or zero if unsigned;
    - half: lane1[7] sign, or zero if unsigned;
    - word: no extension.
  - Writes leave cpu_read_data unchanged.
  - Next state is always IDLE. The still-present request is not re-accepted in DONE.
- cpu_read_data holds its value until the next load completes.
- cpu_read_data is valid in IDLE after DONE. Write-back into the register file occurs on the DONE edge, from the value registered at the end of TRANSFER: assemble lanes combinationally into a next-value register updated on the final-byte handshake so it is valid during DONE.
- Load latency: 1 (accept) + N handshake cycles + 1 (DONE). With bus_ready tied high, a word load stalls the cpu for 5 cycles.
- No address alignment is enforced; misaligned accesses simply use consecutive bytes.
- error is cleared only by reset.

Decomposition:
- Package bus_pkg holds:
  - enum state_t {IDLE, TRANSFER, DONE};
  - enum access_size_t {Byte=0, Half=1, Word=2};
  - function bytes_for(access_size_t) returning 1/2/4;
  - localparam BusDataWidth = 8.
- One natural sub-module, byte_lane_assembler: four 8-bit lane registers, write strobe by index, and the extension mux.
- FSM, address generation and timeout counter stay in bus_serialiser.

Test Plan:
- Word store, addr 0x10, data 0xDEADBEEF, bus_ready=1 -> 4 beats: (0x10,EF) (0x11,BE) (0x12,AD) (0x13,DE); bus_write_enable=1; stall high 5 cycles.
- Signed byte load, addr 0x20, bus returns 0x80 -> cpu_read_data=0xFFFFFF80. Unsigned -> 0x00000080.
- Half load, addr 0xFF, bytes 0x34 then 0x92, ready delayed 3 cycles per beat -> addresses 0xFF then 0x00 (wrap); result 0xFFFF9234; stall spans all wait cycles.
- bus_ready held low, TIMEOUT_CYCLES=15, byte load -> DONE after 15 waiting cycles; error=1; cpu_read_data=0; next request still serviced.
- Reset asserted during beat 2 of a word store -> bus_valid=0 and stall=0 within the same cycle; state IDLE; no further beats.
- Read and write asserted together, addr 0x40 -> write beats issued; cpu_read_data unchanged.
